// File: rtl/fifo_arb_pkg.sv
// Shared types for the fifo_wr_arb write-port arbiter.
// Optional statistics counters are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;
    typedef enum logic {IDLE, GRANT} arb_state_t;
    localparam int STAT_W = 16;
endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first requesting index strictly
// after 'last', wrapping modulo NREQ.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   idx
);
    int unsigned j;

    // Scan from farthest to nearest so the nearest candidate wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(last) + k) % NREQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers.
// Define FIFO_ARB_STATS_EN to enable per-requester and stall counters.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int DSIZE = 8,
    parameter  int BURST = 4,
    localparam int IW    = $clog2(NREQ),
    localparam int BW    = $clog2(BURST + 1)
) (
    input  logic                   wclk,
    input  logic                   wrst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DSIZE-1:0]  req_data,
    output logic [NREQ-1:0]        ack,
    input  logic                   wfull,
    output logic                   winc,
    output logic [DSIZE-1:0]       wdata,
    output logic [IW-1:0]          owner,
    output logic                   busy,
    output logic [NREQ*STAT_W-1:0] stat_cnt,
    output logic [STAT_W-1:0]      stall_cnt
);
    localparam logic [BW-1:0] BMAX = BW'(BURST - 1);

    arb_state_t      state, state_n;
    logic [IW-1:0]   owner_n, last, last_n;
    logic [BW-1:0]   bcnt, bcnt_n;
    logic [NREQ-1:0] own_oh, pick_req;
    logic [IW-1:0]   pick_last, pick_idx;
    logic            pick_valid, own_req, wr, burst_end;

    assign busy      = (state == GRANT);
    assign own_oh    = NREQ'(1) << owner;
    assign own_req   = req[owner];
    assign wr        = busy & own_req & ~wfull;
    assign burst_end = busy & ((wr & (bcnt == BMAX)) | ~own_req);

    // While granted, the current owner is masked and becomes the pointer.
    assign pick_req  = busy ? (req & ~own_oh) : req;
    assign pick_last = busy ? owner : last;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (pick_req),
        .last  (pick_last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign winc  = wr;
    assign ack   = wr ? own_oh : '0;
    assign wdata = busy ? req_data[int'(owner)*DSIZE +: DSIZE] : '0;

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        bcnt_n  = bcnt;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = GRANT;
                    owner_n = pick_idx;
                    bcnt_n  = '0;
                end
            end
            GRANT: begin
                if (burst_end) begin
                    last_n = owner;
                    bcnt_n = '0;
                    if (pick_valid) begin
                        owner_n = pick_idx;
                    end else if (!own_req) begin
                        state_n = IDLE;
                    end
                end else if (wr) begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state <= IDLE;
            owner <= '0;
            last  <= IW'(NREQ - 1);
            bcnt  <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            bcnt  <= bcnt_n;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] scnt [NREQ];
    logic [STAT_W-1:0] stall;

    // Counters saturate rather than wrap.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            for (int i = 0; i < NREQ; i++) scnt[i] <= '0;
            stall <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] && scnt[i] != '1) scnt[i] <= scnt[i] + 1'b1;
            end
            if (busy && own_req && wfull && stall != '1) stall <= stall + 1'b1;
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NREQ; i++) stat_cnt[i*STAT_W +: STAT_W] = scnt[i];
    end
    assign stall_cnt = stall;
`else
    assign stat_cnt  = '0;
    assign stall_cnt = '0;
`endif
endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter sharing one FIFO write port (`wdata`/`winc`/`wfull`) between `NREQ` producers in the write clock domain. It grants one producer at a time for a burst of up to `BURST` words, then rotates ownership. It sits directly in front of the `fifo2` write side, and its outputs drive `winc`/`wdata` unchanged.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `DSIZE`, 8: data width, matches FIFO `DSIZE`
- `BURST`, 4: max words per grant, 1..16
- `wclk` in 1: write-domain clock, all state on rising edge
- `wrst` in 1: reset, asynchronous, active-high
- `req` in NREQ: producer i has a word on `req_data` slice i
- `req_data` in NREQ*DSIZE: producer words, slice i = bits [i*DSIZE +: DSIZE]
- `ack` out NREQ: one-hot; bit i high in the cycle producer i's word is written
- `wfull` in 1: FIFO full flag (write domain)
- `winc` out 1: FIFO write enable
- `wdata` out DSIZE: FIFO write data
- `owner` out $clog2(NREQ): current grant index
- `busy` out 1: state is GRANT
- `stat_cnt` out NREQ*16: per-requester accepted-word counts
- `stall_cnt` out 16: full-stall cycles

## Operation
- States: IDLE, GRANT. Registers: `state`, `owner`, `bcnt` (burst word count), `last` (previous owner, rotation pointer).
- IDLE: if any `req`, go to GRANT with `owner` set to the first requesting index strictly after `last`, wrapping modulo NREQ. `bcnt`=0.
- GRANT, write condition `wr = req[owner] & ~wfull`:
  - `winc`=`wr`, `wdata`=slice `owner`, `ack`=`wr` << `owner`. All are combinational from registered `owner`/`state`.
  - on `wr`: `bcnt`+1.
- Burst end: (`wr` and `bcnt`==BURST-1), or `req[owner]`=0.
  - At burst end, `last`<=`owner`. Re-arbitrate in the same cycle using `req` with `req[owner]` masked.
  - If another requester is pending, stay in GRANT with the new `owner`, `bcnt`=0, and no bubble.
  - Otherwise, if `req[owner]` is still high, re-grant the same owner. Otherwise go to IDLE.
- `wfull` high in GRANT: no write, `bcnt` holds, owner holds. A stall never ends a burst.
- The producer must hold `req_data` stable while `req` is high and `ack` is low. A word is consumed only on `ack`.
- `busy` = (state==GRANT).

## Timing
- Reset values: `state`=IDLE, `owner`=0, `last`=NREQ-1 (so the first grant goes to requester 0 when it requests), `bcnt`=0, `winc`=0, `ack`=0, `wdata`=0 (muxed from slice 0 but gated to 0 when not GRANT), `busy`=0, counters 0.
- Latency: `req` rising in cycle N from IDLE gives the first `winc` in cycle N+1.
- Burst to burst: zero idle cycles.
- Throughput: 1 word per cycle while not full.
- `wrst` asserted mid-burst: all registers clear immediately and `winc` drops asynchronously. No partial word is written.
- `bcnt` width is $clog2(BURST+1). `owner` compare wraps modulo NREQ.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - `stat_cnt` slice i increments on `ack[i]`.
  - `stall_cnt` increments each GRANT cycle with `req[owner]` & `wfull`.
  - Both are 16-bit, saturate at 0xFFFF, and clear on `wrst`.
- Undefined: counter logic is removed, and `stat_cnt`/`stall_cnt` are tied to 0. Ports remain present so instantiation is unchanged.

## Structure
- `fifo_arb_pkg`: `typedef enum logic {IDLE, GRANT} arb_state_t;` and `localparam STAT_W = 16`.
- One sub-module, `rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector, `last` pointer.
  - Outputs: `valid`, `idx`.
  - Instantiated once, fed with the masked or unmasked request vector.

## Test plan
- Single requester: `req`=4'b0001, data 0x10..0x17, FIFO never full -> `winc` 8 consecutive cycles. Words written in order 0x10..0x17. Bursts of 4 re-grant owner 0 with no bubble.
- All four requesting continuously, BURST=4 -> owner sequence 0,1,2,3,0. Exactly 4 `ack` per grant. No idle cycle between grants.
- `wfull` pulsed for 3 cycles mid-burst (after word 2) -> `winc`=0 for those 3 cycles. `bcnt` holds. Owner continues with words 3 and 4, then rotates.
- Requester 1 drops `req` after 2 words while 2 is pending -> grant moves to 2 on the next cycle. Requester 1's burst is 2 words.
- `wrst` asserted asynchronously mid-burst -> `winc`, `ack`, `busy` go to 0 immediately. After release, the first grant goes to the lowest pending requester starting at 0.
- With `FIFO_ARB_STATS_EN`: 70000 words from requester 0 -> `stat_cnt[15:0]`=0xFFFF (saturated). 5 full cycles -> `stall_cnt`=5. Without the macro, both read 0.
